multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter: WAIT_LIMIT, default 15, max cycles a memory state waits for mem_ready before timeout (range 1..255).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 opcode  in  6  instruction opcode from instruction register, sampled in DECODE only.
REQ-006 mem_ready  in  1  memory completes current read/write this cycle.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, RegWrite, RegDst, ALUSrcA  out  1 each  multicycle datapath controls.
REQ-008 ALUSrcB, ALUOp, PCSource  out  2 each  datapath mux and ALU controls.
REQ-009 illegal_op  out  1  one-cycle pulse: unsupported opcode decoded.
REQ-010 mem_timeout  out  1  one-cycle pulse: memory wait exceeded WAIT_LIMIT.
REQ-011 instr_done  out  1  one-cycle pulse in the last cycle of every completed instruction.

Function
REQ-012 FSM states: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, BRANCH, JUMP; one transition per clock.
REQ-013 Every output SHALL be 0 in any state or cycle not listed below; no X is ever driven.
REQ-014 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=1 only in the cycle mem_ready=1, then go DECODE; else stay.
REQ-015 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; next by opcode: 000000->R_EXEC, 100011/101011->MEM_ADDR, 000100->BRANCH, other->FETCH with illegal_op=1.
REQ-016 MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next MEM_READ for lw, MEM_WRITE for sw (opcode latched in DECODE).
REQ-017 MEM_READ: MemRead=1, IorD=1; go MEM_WB on mem_ready, else stay.
REQ-018 MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1; go FETCH.
REQ-019 MEM_WRITE: MemWrite=1, IorD=1; on mem_ready instr_done=1, go FETCH; else stay.
REQ-020 R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; go R_WB.
REQ-021 R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1; go FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1; go FETCH.
REQ-023 Latencies (mem_ready always 1): R-type 4, lw 5, sw 4, beq 3 cycles.
REQ-024 Wait counter: 8-bit, cleared on entry to FETCH/MEM_READ/MEM_WRITE and whenever mem_ready=1, increments each waiting cycle there.
REQ-025 When the counter reaches WAIT_LIMIT with mem_ready=0: mem_timeout=1 that cycle, MemRead/MemWrite/IRWrite/PCWrite held 0 that cycle, next state FETCH, no instr_done.
REQ-026 mem_ready=1 in the same cycle the counter reaches WAIT_LIMIT: completion wins, no timeout.
REQ-027 mem_ready outside FETCH/MEM_READ/MEM_WRITE is ignored.

Reset
REQ-028 rst_n low SHALL immediately force state FETCH, counter 0, latched opcode 000000, all outputs to FETCH-entry values with IRWrite=PCWrite=0 until first cycle after deassertion.
REQ-029 Reset mid-instruction discards it; no instr_done, RegWrite or MemWrite is produced for the aborted instruction.

Configuration
REQ-030 Macro MULTICYCLE_JUMP_EN: when defined, DECODE maps opcode 000010 to JUMP (PCWrite=1, PCSource=10, instr_done=1, then FETCH; j latency 3).
REQ-031 Without MULTICYCLE_JUMP_EN, state JUMP does not exist and opcode 000010 is illegal per REQ-015.

Structure
REQ-032 Shared package mc_pkg: state enumeration, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J), ALUOp and PCSource encodings.
REQ-033 One sub-module mc_wait_timer: counter with clear, enable, WAIT_LIMIT parameter and expired output.

Verification
REQ-034 R-type 000000, mem_ready=1 -> states FETCH,DECODE,R_EXEC,R_WB; RegWrite=RegDst=1 in cycle 4; instr_done once.
REQ-035 lw 100011, mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, then MEM_WB with MemtoReg=1; total 8 cycles.
REQ-036 Opcode 111111 -> illegal_op pulses in DECODE, next state FETCH, no RegWrite/MemWrite.
REQ-037 WAIT_LIMIT=3, mem_ready=0 in FETCH -> mem_timeout in 4th FETCH cycle, IRWrite never 1, stays FETCH.
REQ-038 rst_n low during MEM_WRITE -> same-cycle MemWrite=0, state FETCH; no instr_done.
REQ-039 Opcode 000010 -> JUMP with PCSource=10 when MULTICYCLE_JUMP_EN defined; illegal_op pulse when undefined.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared states, opcodes and control encodings for multicycle_control (MULTICYCLE_JUMP_EN adds S_JUMP)
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_R_EXEC,
        S_R_WB,
        S_BRANCH
`ifdef MULTICYCLE_JUMP_EN
        , S_JUMP
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    // States that wait on mem_ready and are guarded by the wait timer.
    function automatic logic is_mem_wait(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath/memory signal bundle
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDst;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic       mem_timeout;
    logic       instr_done;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, mem_timeout, instr_done
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
               IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, mem_timeout, instr_done
    );
endinterface

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - 8-bit memory wait counter; expired when count equals WAIT_LIMIT
module mc_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] count,
    output logic       expired
);

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    logic [7:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (en) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign expired = (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory wait timeout (MULTICYCLE_JUMP_EN enables j)
module multicycle_control
    import mc_pkg::*;
#(
    parameter int WAIT_LIMIT = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        bus
);

    state_t     state_d, state_q;
    logic [5:0] op_d, op_q;

    logic       wait_st;
    logic       expired;
    logic       timeout;
    logic       tmr_clr;
    logic       tmr_en;
    logic [7:0] tmr_count;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, memto_reg;
    logic       ir_write, reg_write, reg_dst, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op, mem_timeout, instr_done;

    mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .count   (tmr_count),
        .expired (expired)
    );

    // Completion takes priority over expiry when both land in the same cycle.
    assign wait_st = is_mem_wait(state_q);
    assign timeout = wait_st && expired && !bus.mem_ready;
    assign tmr_clr = !wait_st || bus.mem_ready || timeout;
    assign tmr_en  = wait_st && !bus.mem_ready;

    assign op_d = (state_q == S_DECODE) ? bus.opcode : op_q;

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        memto_reg     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        mem_timeout   = 1'b0;
        instr_done    = 1'b0;

        case (state_q)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                if (timeout) begin
                    mem_timeout = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    mem_read = 1'b1;
                    if (bus.mem_ready) begin
                        // Held low while reset is asserted so no IR/PC update leaks out.
                        ir_write = rst_n;
                        pc_write = rst_n;
                        state_d  = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_BOFS;
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                iord = 1'b1;
                if (timeout) begin
                    mem_timeout = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    mem_read = 1'b1;
                    if (bus.mem_ready) state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                memto_reg  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                iord = 1'b1;
                if (timeout) begin
                    mem_timeout = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    mem_write = 1'b1;
                    if (bus.mem_ready) begin
                        instr_done = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = SRCB_REG;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
`ifdef MULTICYCLE_JUMP_EN
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= OP_RTYPE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign bus.PCWrite     = pc_write;
    assign bus.PCWriteCond = pc_write_cond;
    assign bus.IorD        = iord;
    assign bus.MemRead     = mem_read;
    assign bus.MemWrite    = mem_write;
    assign bus.MemtoReg    = memto_reg;
    assign bus.IRWrite     = ir_write;
    assign bus.RegWrite    = reg_write;
    assign bus.RegDst      = reg_dst;
    assign bus.ALUSrcA     = alu_src_a;
    assign bus.ALUSrcB     = alu_src_b;
    assign bus.ALUOp       = alu_op;
    assign bus.PCSource    = pc_source;
    assign bus.illegal_op  = illegal_op;
    assign bus.mem_timeout = mem_timeout;
    assign bus.instr_done  = instr_done;

    logic unused_ok;
    assign unused_ok = ^tmr_count;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control (WAIT_LIMIT=3)
module tb_multicycle_control;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    multicycle_control_if bus();

    multicycle_control #(.WAIT_LIMIT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,RegWrite,RegDst,ALUSrcA,ALUSrcB,ALUOp,PCSource,illegal_op,mem_timeout,instr_done}
    localparam logic [18:0] PCW     = 19'd1 << 18;
    localparam logic [18:0] PCWC    = 19'd1 << 17;
    localparam logic [18:0] IORD    = 19'd1 << 16;
    localparam logic [18:0] MRD     = 19'd1 << 15;
    localparam logic [18:0] MWR     = 19'd1 << 14;
    localparam logic [18:0] M2R     = 19'd1 << 13;
    localparam logic [18:0] IRW     = 19'd1 << 12;
    localparam logic [18:0] RW      = 19'd1 << 11;
    localparam logic [18:0] RDST    = 19'd1 << 10;
    localparam logic [18:0] SRCA    = 19'd1 << 9;
    localparam logic [18:0] SRCB_01 = 19'd1 << 7;
    localparam logic [18:0] SRCB_10 = 19'd2 << 7;
    localparam logic [18:0] SRCB_11 = 19'd3 << 7;
    localparam logic [18:0] AOP_01  = 19'd1 << 5;
    localparam logic [18:0] AOP_10  = 19'd2 << 5;
    localparam logic [18:0] PCS_01  = 19'd1 << 3;
    localparam logic [18:0] PCS_10  = 19'd2 << 3;
    localparam logic [18:0] ILL     = 19'd1 << 2;
    localparam logic [18:0] TMO     = 19'd1 << 1;
    localparam logic [18:0] DONE    = 19'd1;

    localparam logic [18:0] V_RST     = MRD | SRCB_01;
    localparam logic [18:0] V_F_WAIT  = MRD | SRCB_01;
    localparam logic [18:0] V_F_DONE  = MRD | SRCB_01 | IRW | PCW;
    localparam logic [18:0] V_F_TO    = SRCB_01 | TMO;
    localparam logic [18:0] V_DEC     = SRCB_11;
    localparam logic [18:0] V_DEC_ILL = SRCB_11 | ILL;
    localparam logic [18:0] V_MA      = SRCA | SRCB_10;
    localparam logic [18:0] V_MR      = MRD | IORD;
    localparam logic [18:0] V_MR_TO   = IORD | TMO;
    localparam logic [18:0] V_MWB     = RW | M2R | DONE;
    localparam logic [18:0] V_MW      = MWR | IORD;
    localparam logic [18:0] V_MW_DONE = MWR | IORD | DONE;
    localparam logic [18:0] V_REX     = SRCA | AOP_10;
    localparam logic [18:0] V_RWB     = RW | RDST | DONE;
    localparam logic [18:0] V_BR      = SRCA | AOP_01 | PCWC | PCS_01 | DONE;
    localparam logic [18:0] V_JMP     = PCW | PCS_10 | DONE;

    typedef struct {
        logic [18:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [18:0] got;
    assign got = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.MemtoReg, bus.IRWrite, bus.RegWrite, bus.RegDst, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ALUOp, bus.PCSource,
                  bus.illegal_op, bus.mem_timeout, bus.instr_done};

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_checks++;
                if (got !== e.v) begin
                    n_errors++;
                    $display("FAIL %s: got %05h expected %05h", e.name, got, e.v);
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic [5:0] op, input logic rdy,
                       input logic [18:0] v, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n         = r;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        e.v           = v;
        e.name        = name;
        exp_q.push_back(e);
    endtask

    initial begin
        bus.opcode    = 6'h3f;
        bus.mem_ready = 1'b1;

        cyc(0, 6'h3f, 1, V_RST, "reset_hold0");
        cyc(0, 6'h3f, 1, V_RST, "reset_hold1");

        // R-type: opcode is garbage outside DECODE
        cyc(1, 6'h3f, 1, V_F_DONE, "r_fetch");
        cyc(1, 6'h00, 1, V_DEC,    "r_decode");
        cyc(1, 6'h3f, 1, V_REX,    "r_exec");
        cyc(1, 6'h3f, 1, V_RWB,    "r_wb");

        // lw, 3 wait cycles then ready exactly when counter hits the limit
        cyc(1, 6'h3f, 1, V_F_DONE, "lw_fetch");
        cyc(1, 6'h23, 1, V_DEC,    "lw_decode");
        cyc(1, 6'h2b, 1, V_MA,     "lw_addr");
        for (int i = 0; i < 3; i++) cyc(1, 6'h2b, 0, V_MR, "lw_read_wait");
        cyc(1, 6'h00, 1, V_MR,     "lw_read_ready_at_limit");
        cyc(1, 6'h00, 1, V_MWB,    "lw_wb");

        // sw
        cyc(1, 6'h00, 1, V_F_DONE,  "sw_fetch");
        cyc(1, 6'h2b, 1, V_DEC,     "sw_decode");
        cyc(1, 6'h23, 1, V_MA,      "sw_addr");
        cyc(1, 6'h00, 1, V_MW_DONE, "sw_write");

        // beq
        cyc(1, 6'h00, 1, V_F_DONE, "beq_fetch");
        cyc(1, 6'h04, 1, V_DEC,    "beq_decode");
        cyc(1, 6'h00, 1, V_BR,     "beq_branch");

        // illegal opcode
        cyc(1, 6'h00, 1, V_F_DONE,  "ill_fetch");
        cyc(1, 6'h3f, 1, V_DEC_ILL, "ill_decode");

        // j
        cyc(1, 6'h00, 1, V_F_DONE, "j_fetch");
`ifdef MULTICYCLE_JUMP_EN
        cyc(1, 6'h02, 1, V_DEC, "j_decode");
        cyc(1, 6'h00, 1, V_JMP, "j_jump");
`else
        cyc(1, 6'h02, 1, V_DEC_ILL, "j_decode_illegal");
`endif

        // FETCH timeout in the 4th waiting cycle, then FETCH restarts its wait
        for (int i = 0; i < 3; i++) cyc(1, 6'h00, 0, V_F_WAIT, "fetch_wait");
        cyc(1, 6'h00, 0, V_F_TO,   "fetch_timeout");
        cyc(1, 6'h00, 0, V_F_WAIT, "fetch_rewait0");
        cyc(1, 6'h00, 0, V_F_WAIT, "fetch_rewait1");
        cyc(1, 6'h00, 1, V_F_DONE, "fetch_after_to");

        // MEM_READ timeout aborts the load
        cyc(1, 6'h23, 1, V_DEC, "lwto_decode");
        cyc(1, 6'h00, 0, V_MA,  "lwto_addr_ready_ignored");
        for (int i = 0; i < 3; i++) cyc(1, 6'h00, 0, V_MR, "lwto_read_wait");
        cyc(1, 6'h00, 0, V_MR_TO,  "lwto_timeout");
        cyc(1, 6'h00, 1, V_F_DONE, "lwto_refetch");

        // reset during MEM_WRITE
        cyc(1, 6'h2b, 1, V_DEC,    "swrst_decode");
        cyc(1, 6'h00, 1, V_MA,     "swrst_addr");
        cyc(1, 6'h00, 0, V_MW,     "swrst_write_wait");
        cyc(0, 6'h00, 1, V_RST,    "swrst_reset");
        cyc(1, 6'h00, 1, V_F_DONE, "swrst_refetch");
        cyc(1, 6'h00, 1, V_DEC,    "swrst_decode_rtype");

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
